// File: rtl/dbus_access.sv
// dbus_access - MEM-stage load/store unit between EX/MEM and the data bus.
//
// Turns one pipeline memory operation into a dbus_req_t transaction. The
// request is driven combinationally in the issue cycle. Latched copies then
// hold it stable until dresp.data_ok. Load data is aligned and extended,
// and done pulses one cycle after data_ok.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   op_valid/op_load/op_store/op_size/op_unsigned/op_addr/op_wdata/op_flush
//                   memory operation from EX/MEM
//   dreq            bus request (valid, addr, size, strobe, data)
//   dresp           bus response (addr_ok ignored, data_ok, data)
//   stall           hold MEM and upstream stages
//   done            one-cycle result-valid pulse
//   ldata           extended load data (0 for stores)
//   misalign        misaligned access flag
//
// Optional feature: define DBUS_MISALIGN_CHECK_EN to reject misaligned
// accesses in IDLE with misalign=1 instead of issuing them.

package dbus_pkg;
   localparam int DBUS_ADDR_W = 64;
   localparam int DBUS_DATA_W = 64;

   typedef struct packed {
      logic                   valid;
      logic [DBUS_ADDR_W-1:0] addr;
      logic [2:0]             size;
      logic [7:0]             strobe;
      logic [DBUS_DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic                   addr_ok;
      logic                   data_ok;
      logic [DBUS_DATA_W-1:0] data;
   } dbus_resp_t;
endpackage

module dbus_access
   import dbus_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic              op_load,
   input  logic              op_store,
   input  logic [2:0]        op_size,
   input  logic              op_unsigned,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [DATA_W-1:0] op_wdata,
   input  logic              op_flush,
   output dbus_req_t         dreq,
   input  dbus_resp_t        dresp,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] ldata,
   output logic              misalign
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   // Unshifted byte-lane mask for an access size.
   function automatic logic [7:0] base_mask(input logic [2:0] size);
      case (size)
         3'b000:  base_mask = 8'h01;
         3'b001:  base_mask = 8'h03;
         3'b010:  base_mask = 8'h0F;
         3'b011:  base_mask = 8'hFF;
         default: base_mask = 8'h00;
      endcase
   endfunction

   // Shift the lane holding the datum down to bit 0, then extend.
   function automatic logic [63:0] align_load(input logic [63:0] raw, input logic [2:0] off,
                                              input logic [2:0] size, input logic uns);
      logic [63:0] sh;
      sh = raw >> {off, 3'b000};
      case (size)
         3'b000:  align_load = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         3'b001:  align_load = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         3'b010:  align_load = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: align_load = sh;
      endcase
   endfunction

`ifdef DBUS_MISALIGN_CHECK_EN
   // True when the low address bits are not a multiple of the access size.
   function automatic logic is_misaligned(input logic [2:0] off, input logic [2:0] size);
      case (size)
         3'b000:  is_misaligned = 1'b0;
         3'b001:  is_misaligned = off[0];
         3'b010:  is_misaligned = |off[1:0];
         3'b011:  is_misaligned = |off;
         default: is_misaligned = 1'b0;
      endcase
   endfunction
`endif

   state_t              state_r, state_nxt_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [2:0]          size_r;
   logic [7:0]          strobe_r;
   logic [DATA_W-1:0]   wdata_r;
   logic                load_r, uns_r, drop_r, done_r;
   logic [DATA_W-1:0]   ldata_r;
   logic                drop_nxt_s, done_nxt_s;
   logic [DATA_W-1:0]   ldata_nxt_s;
   logic                mem_op_s, misalign_s, issue_s;
   logic [7:0]          req_strobe_s;
   logic [DATA_W-1:0]   req_wdata_s;
   logic [2:0]          sel_off_s, sel_size_s;
   logic                sel_load_s, sel_uns_s;
   logic [DATA_W-1:0]   result_s;
   logic                unused_addr_ok_s;

   assign unused_addr_ok_s = dresp.addr_ok;
   assign mem_op_s = !reset && (state_r == IDLE) && op_valid && (op_load || op_store) && !op_flush;

`ifdef DBUS_MISALIGN_CHECK_EN
   assign misalign_s = mem_op_s && is_misaligned(op_addr[2:0], op_size);
`else
   assign misalign_s = 1'b0;
`endif

   assign issue_s      = mem_op_s && !misalign_s;
   assign req_strobe_s = op_store ? (base_mask(op_size) << op_addr[2:0]) : 8'h00;
   assign req_wdata_s  = op_wdata << {op_addr[2:0], 3'b000};

   // Attributes of the access being completed: live inputs in IDLE, latched copies otherwise.
   always_comb begin
      sel_off_s  = addr_r[2:0];
      sel_size_s = size_r;
      sel_load_s = load_r;
      sel_uns_s  = uns_r;
      if (state_r == IDLE) begin
         sel_off_s  = op_addr[2:0];
         sel_size_s = op_size;
         sel_load_s = op_load;
         sel_uns_s  = op_unsigned;
      end else begin
         sel_off_s  = addr_r[2:0];
      end
      result_s = sel_load_s ? align_load(dresp.data, sel_off_s, sel_size_s, sel_uns_s) : 64'd0;
   end

   // Next-state, bus request and stall.
   always_comb begin
      state_nxt_s = state_r;
      dreq        = '0;
      stall       = 1'b0;
      drop_nxt_s  = drop_r;
      done_nxt_s  = 1'b0;
      ldata_nxt_s = 64'd0;
      case (state_r)
         IDLE: begin
            drop_nxt_s = 1'b0;
            if (issue_s) begin
               dreq.valid  = 1'b1;
               dreq.addr   = op_addr;
               dreq.size   = op_size;
               dreq.strobe = req_strobe_s;
               dreq.data   = req_wdata_s;
               stall       = 1'b1;
               if (dresp.data_ok) begin
                  state_nxt_s = DONE;
                  done_nxt_s  = 1'b1;
                  ldata_nxt_s = result_s;
               end else begin
                  state_nxt_s = WAIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            dreq.valid  = 1'b1;
            dreq.addr   = addr_r;
            dreq.size   = size_r;
            dreq.strobe = strobe_r;
            dreq.data   = wdata_r;
            stall       = 1'b1;
            // A flush cannot abort the bus cycle; it only suppresses done.
            drop_nxt_s  = drop_r || op_flush;
            if (dresp.data_ok) begin
               state_nxt_s = DONE;
               done_nxt_s  = !(drop_r || op_flush);
               ldata_nxt_s = result_s;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
            drop_nxt_s  = 1'b0;
         end
         default: begin
            state_nxt_s = IDLE;
            drop_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, latched request copies and registered results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         addr_r   <= '0;
         size_r   <= 3'b000;
         strobe_r <= 8'h00;
         wdata_r  <= '0;
         load_r   <= 1'b0;
         uns_r    <= 1'b0;
         drop_r   <= 1'b0;
         done_r   <= 1'b0;
         ldata_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         drop_r  <= drop_nxt_s;
         done_r  <= done_nxt_s;
         ldata_r <= ldata_nxt_s;
         if (issue_s) begin
            addr_r   <= op_addr;
            size_r   <= op_size;
            strobe_r <= req_strobe_s;
            wdata_r  <= req_wdata_s;
            load_r   <= op_load;
            uns_r    <= op_unsigned;
         end
      end
   end

   assign done     = done_r;
   assign ldata    = ldata_r;
   assign misalign = misalign_s;

endmodule

// File: doc/dbus_access.md
Name: dbus_access

Overview:
- MEM-stage load/store unit sitting between the EX/MEM pipeline register and the core's data-bus port.
- Converts one pipeline memory operation into a dbus_req_t transaction and holds it stable until the bus acknowledges.
- Aligns and extends load data, and stalls the pipeline while the access is outstanding.
- Its output feeds the MEM/WB register.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data width; fixed at 64, and byte lanes are 8.

Ports:
- clk  input  1  clock, shared with the core
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  EX/MEM holds a valid memory operation
- op_load  input  1  operation is a load
- op_store  input  1  operation is a store; op_load and op_store are never both high
- op_size  input  3  000=1B, 001=2B, 010=4B, 011=8B; other codes are illegal
- op_unsigned  input  1  load is zero-extended (LBU/LHU/LWU)
- op_addr  input  64  effective address
- op_wdata  input  64  store data, LSB-aligned
- op_flush  input  1  discard the result of the current operation
- dreq  output  dbus_req_t  fields valid, addr, size, strobe, data
- dresp  input  dbus_resp_t  fields addr_ok, data_ok, data
- stall  output  1  hold the pipeline (MEM stage and all stages upstream)
- done  output  1  one-cycle pulse: result valid this cycle
- ldata  output  64  extended load data; 0 for stores
- misalign  output  1  misaligned access detected (optional feature)

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high: all state is sampled on the clk rising edge while reset is high.
  - Reset values: state=IDLE, dreq.valid=0, dreq.strobe=0, stall=0, done=0, ldata=0, misalign=0.
- State machine (IDLE, WAIT, DONE):
  - IDLE: if op_valid and (op_load or op_store) and not op_flush, drive dreq combinationally the same cycle, set stall=1, and go to WAIT. If data_ok is already high that cycle, go directly to DONE. Otherwise stay in IDLE with stall=0.
  - WAIT: dreq.valid=1, with addr, size, strobe and data taken from latched copies. They stay stable until data_ok. stall=1. On data_ok, latch the aligned result and go to DONE.
  - DONE: dreq.valid=0, stall=0, done=1, ldata = latched result. The pipeline advances at the end of this cycle. Always return to IDLE; a new request is never issued from DONE.
- Request fields:
  - addr = op_addr unmodified; size = op_size.
  - strobe: 0 for loads. For stores, base mask (8'h01, 8'h03, 8'h0F, 8'hFF for 1B/2B/4B/8B) shifted left by addr[2:0].
  - data = op_wdata << (8*addr[2:0]), truncated to 64 bits.
- Load result:
  - Shift dresp.data right by 8*addr[2:0], then keep the low 1/2/4/8 bytes.
  - Sign-extend unless op_unsigned; 8B loads ignore op_unsigned.
  - Latency: minimum 1 extra cycle (request in cycle N, data_ok in N, done in N+1). In general, done comes exactly one cycle after data_ok.
- Flush:
  - op_flush in IDLE: no request is issued.
  - op_flush in WAIT: the transaction is not aborted. The unit keeps waiting for data_ok, sets an internal drop flag, and done stays 0 in the following DONE cycle.
- Edge cases:
  - addr_ok is ignored; only data_ok completes the access.
  - data_ok while in IDLE with no request outstanding is ignored.
  - Reset mid-WAIT: IDLE on the next cycle, dreq.valid=0, and a late data_ok is ignored.
  - op_valid with neither load nor store: pass-through, no request, stall=0, done=0.

Optional Feature:
- Macro: DBUS_MISALIGN_CHECK_EN.
- When defined:
  - In IDLE, an access whose addr is not a multiple of its size raises misalign=1 for that cycle.
  - No bus request is issued; stall=0, done=0, and the state stays IDLE.
  - The pipeline routes the exception.
- When undefined:
  - misalign is tied to 0 and unaligned addresses are issued to the bus unchanged.
  - strobe may wrap past lane 7; bits beyond lane 7 are dropped by the truncation.

Test Plan:
- LW signed: addr=0x80001004, size=010, op_unsigned=0, data_ok after 3 cycles with data=0x8765432100000000 -> dreq held stable for 3 cycles, strobe=0, stall=1 throughout, done one cycle after data_ok with ldata=0xFFFFFFFF87654321.
- SB: addr=0x80000003, wdata=0xAB, data_ok on the same cycle as the request -> strobe=8'h08, data[31:24]=0xAB, DONE the next cycle, done=1, ldata=0.
- LBU: addr offset 7, dresp.data=0xF0000000_00000000 -> ldata=0xF0. The same access with op_unsigned=0 -> ldata=0xFFFFFFFFFFFFFFF0.
- Flush in WAIT: op_flush asserted two cycles before data_ok -> request remains stable until data_ok, done stays 0, and the unit returns to IDLE.
- Reset mid-WAIT, then a stray data_ok the following cycle -> dreq.valid=0 and stall=0 after reset, done never pulses, state IDLE.
- With DBUS_MISALIGN_CHECK_EN defined: 4B load at addr=0x80000002 -> misalign=1, dreq.valid=0, stall=0. With the macro undefined, the same load issues with addr=0x80000002.
